// File: rtl/dmem_access_controller.sv
// Load/store sequencer between the MEM stage and byte-addressed data memory:
// lane decode, ready handshake with timeout, and load extension.
module dmem_access_controller #(
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] STORE_DATA,
    output logic [31:0] LOAD_DATA,
    output logic        BUSY,
    output logic        FAULT,
    output logic [1:0]  FAULT_CODE,
    output logic        DM_READ,
    output logic        DM_WRITE,
    output logic [31:0] DM_ADDRESS,
    output logic [31:0] DM_WRITEDATA,
    output logic [3:0]  DM_BYTE_EN,
    input  logic [31:0] DM_READDATA,
    input  logic        DM_READY
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 op_store;
    logic [2:0]           f3_q;
    logic [1:0]           a_q;

    logic        req;
    logic        illegal_f3;
    logic        misaligned;
    logic [1:0]  fault_code_n;
    logic [3:0]  byte_en_n;
    logic [31:0] wdata_n;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    // A simultaneous read and write is treated as a store.
    assign req        = MEM_READ | MEM_WRITE;
    assign illegal_f3 = (FUNCT3 == 3'b011) || (FUNCT3 == 3'b110) || (FUNCT3 == 3'b111)
                        || (MEM_WRITE && FUNCT3[2]);
    assign misaligned = ((FUNCT3[1:0] == 2'b01) && ADDRESS[0])
                        || ((FUNCT3 == 3'b010) && (ADDRESS[1:0] != 2'b00));

    always_comb begin
        fault_code_n = 2'b00;
        if (illegal_f3)
            fault_code_n = 2'b10;
        else if (misaligned)
            fault_code_n = 2'b01;
    end

    always_comb begin
        byte_en_n = 4'b1111;
        wdata_n   = STORE_DATA;
        case (FUNCT3[1:0])
            2'b00: begin
                byte_en_n = 4'b0001 << ADDRESS[1:0];
                wdata_n   = {4{STORE_DATA[7:0]}};
            end
            2'b01: begin
                byte_en_n = 4'b0011 << ADDRESS[1:0];
                wdata_n   = {2{STORE_DATA[15:0]}};
            end
            default: ;
        endcase
    end

    assign lane_b = DM_READDATA[{a_q, 3'b000} +: 8];
    assign lane_h = a_q[1] ? DM_READDATA[31:16] : DM_READDATA[15:0];

    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_ext = {24'b0, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_ext = {16'b0, lane_h};
            default: load_ext = DM_READDATA;
        endcase
    end

    // Stall is raised in the launch cycle itself so the pipeline freezes immediately.
    assign BUSY     = ((state == S_IDLE) && req && (fault_code_n == 2'b00)) || (state == S_WAIT);
    assign DM_READ  = (state == S_WAIT) && !op_store;
    assign DM_WRITE = (state == S_WAIT) && op_store;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_IDLE;
            cnt          <= '0;
            op_store     <= 1'b0;
            f3_q         <= '0;
            a_q          <= '0;
            LOAD_DATA    <= '0;
            FAULT        <= 1'b0;
            FAULT_CODE   <= '0;
            DM_ADDRESS   <= '0;
            DM_WRITEDATA <= '0;
            DM_BYTE_EN   <= '0;
        end else begin
            FAULT <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (fault_code_n != 2'b00) begin
                            FAULT      <= 1'b1;
                            FAULT_CODE <= fault_code_n;
                        end else begin
                            DM_ADDRESS   <= {ADDRESS[31:2], 2'b00};
                            DM_BYTE_EN   <= byte_en_n;
                            DM_WRITEDATA <= wdata_n;
                            op_store     <= MEM_WRITE;
                            f3_q         <= FUNCT3;
                            a_q          <= ADDRESS[1:0];
                            cnt          <= '0;
                            state        <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (DM_READY) begin
                        if (!op_store)
                            LOAD_DATA <= load_ext;
                        state <= S_RESP;
                    end else if (cnt == LAST) begin
                        FAULT      <= 1'b1;
                        FAULT_CODE <= 2'b11;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_controller.sv
// Scoreboard bench for dmem_access_controller: directed accesses push expected
// launch/response records; a negedge monitor pops and compares them.
module tb_dmem_access_controller;

    localparam int TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ, MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDRESS, STORE_DATA;
    logic [31:0] LOAD_DATA;
    logic        BUSY, FAULT;
    logic [1:0]  FAULT_CODE;
    logic        DM_READ, DM_WRITE;
    logic [31:0] DM_ADDRESS, DM_WRITEDATA;
    logic [3:0]  DM_BYTE_EN;
    logic [31:0] DM_READDATA;
    logic        DM_READY;

    dmem_access_controller #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(5)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .FUNCT3(FUNCT3), .ADDRESS(ADDRESS), .STORE_DATA(STORE_DATA),
        .LOAD_DATA(LOAD_DATA), .BUSY(BUSY), .FAULT(FAULT), .FAULT_CODE(FAULT_CODE),
        .DM_READ(DM_READ), .DM_WRITE(DM_WRITE), .DM_ADDRESS(DM_ADDRESS),
        .DM_WRITEDATA(DM_WRITEDATA), .DM_BYTE_EN(DM_BYTE_EN),
        .DM_READDATA(DM_READDATA), .DM_READY(DM_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        chk_lanes;
    } launch_t;

    typedef struct packed {
        logic        fault;
        logic [1:0]  code;
        logic [31:0] ld;
        logic [7:0]  busy;
        logic [7:0]  strb;
    } resp_t;

    launch_t launch_q[$];
    resp_t   resp_q[$];

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: launch checked on strobe rise, response on end of stall or a fault pulse.
    initial begin
        logic    prev_busy, prev_strb;
        int      busy_cnt, strb_cnt;
        launch_t l;
        resp_t   r;
        prev_busy = 0; prev_strb = 0; busy_cnt = 0; strb_cnt = 0;
        forever begin
            @(negedge CLK);
            if (!mon_en) begin
                prev_busy = 0; prev_strb = 0; busy_cnt = 0; strb_cnt = 0;
            end else begin
                if (BUSY) busy_cnt++;
                if (DM_READ || DM_WRITE) strb_cnt++;
                if ((DM_READ || DM_WRITE) && !prev_strb) begin
                    if (launch_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL launch_unexpected: strobe with no expected launch");
                    end else begin
                        l = launch_q.pop_front();
                        chk("dm_read", 32'(DM_READ), 32'(l.rd));
                        chk("dm_write", 32'(DM_WRITE), 32'(l.wr));
                        chk("dm_address", DM_ADDRESS, l.addr);
                        if (l.chk_lanes) begin
                            chk("dm_byte_en", 32'(DM_BYTE_EN), 32'(l.be));
                            chk("dm_writedata", DM_WRITEDATA, l.wd);
                        end
                    end
                end
                if ((prev_busy && !BUSY) || FAULT) begin
                    if (resp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL resp_unexpected: completion with no expected response");
                    end else begin
                        r = resp_q.pop_front();
                        chk("fault", 32'(FAULT), 32'(r.fault));
                        chk("fault_code", 32'(FAULT_CODE), 32'(r.code));
                        chk("load_data", LOAD_DATA, r.ld);
                        chk("busy_cycles", 32'(busy_cnt), 32'(r.busy));
                        chk("strobe_cycles", 32'(strb_cnt), 32'(r.strb));
                    end
                    busy_cnt = 0; strb_cnt = 0;
                end
                prev_busy = BUSY;
                prev_strb = DM_READ || DM_WRITE;
            end
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rdata, input int wait_n, input bit tmo,
                          input bit chk_lanes, input logic [31:0] e_addr,
                          input logic [3:0] e_be, input logic [31:0] e_wd,
                          input logic [31:0] e_ld, input logic [1:0] e_code);
        launch_t l;
        resp_t   r;
        l = '{rd: rd & ~wr, wr: wr, addr: e_addr, be: e_be, wd: e_wd, chk_lanes: chk_lanes};
        r = '{fault: tmo, code: e_code, ld: e_ld,
              busy: tmo ? 8'(TIMEOUT + 1) : 8'(wait_n + 2),
              strb: tmo ? 8'(TIMEOUT) : 8'(wait_n + 1)};
        launch_q.push_back(l);
        resp_q.push_back(r);
        MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = addr; STORE_DATA = sd;
        DM_READY = 1'b0;
        tick();
        if (tmo) begin
            repeat (TIMEOUT) tick();
        end else begin
            repeat (wait_n) tick();
            DM_READY = 1'b1; DM_READDATA = rdata;
            tick();
            DM_READY = 1'b0; DM_READDATA = 32'h0;
        end
        MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        tick();
    endtask

    task automatic bad_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] e_ld,
                              input logic [1:0] e_code);
        resp_t r;
        r = '{fault: 1'b1, code: e_code, ld: e_ld, busy: 8'd0, strb: 8'd0};
        resp_q.push_back(r);
        MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = addr; STORE_DATA = 32'hFFFF_FFFF;
        tick();
        MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        launch_t l;
        RESET = 1'b1; MEM_READ = 0; MEM_WRITE = 0; FUNCT3 = 0; ADDRESS = 0;
        STORE_DATA = 0; DM_READDATA = 0; DM_READY = 0;
        repeat (2) tick();
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_strobes", 32'({DM_READ, DM_WRITE, FAULT}), 32'd0);
        chk("rst_load_data", LOAD_DATA, 32'h0);
        chk("rst_dm_address", DM_ADDRESS, 32'h0);
        chk("rst_fault_code", 32'(FAULT_CODE), 32'd0);
        mon_en = 1'b1;
        tick();

        //      rd wr f3      addr          sd            rdata        wait tmo lanes e_addr      e_be     e_wd          e_ld          code
        access(0, 1, 3'b000, 32'h0000_0102, 32'h1234_56AB, 32'h0,        1, 0, 1, 32'h100, 4'b0100, 32'hABAB_ABAB, 32'h0,         2'b00);
        access(1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h8000_0000, 0, 0, 0, 32'h100, 4'b0,    32'h0,         32'hFFFF_FF80, 2'b00);
        access(1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h8000_0000, 0, 0, 0, 32'h100, 4'b0,    32'h0,         32'h0000_0080, 2'b00);
        access(1, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_0000, 0, 0, 0, 32'h100, 4'b0,    32'h0,         32'hFFFF_8001, 2'b00);
        access(1, 0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_0000, 0, 0, 0, 32'h100, 4'b0,    32'h0,         32'h0000_8001, 2'b00);
        access(1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 2, 0, 0, 32'h100, 4'b0,    32'h0,         32'hDEAD_BEEF, 2'b00);
        access(0, 1, 3'b001, 32'h0000_0002, 32'h0000_CAFE, 32'h0,        0, 0, 1, 32'h000, 4'b1100, 32'hCAFE_CAFE, 32'hDEAD_BEEF, 2'b00);

        bad_access(1, 0, 3'b010, 32'h0000_0101, 32'hDEAD_BEEF, 2'b01);
        bad_access(0, 1, 3'b011, 32'h0000_0100, 32'hDEAD_BEEF, 2'b10);
        bad_access(0, 1, 3'b101, 32'h0000_0101, 32'hDEAD_BEEF, 2'b10);
        bad_access(1, 0, 3'b001, 32'h0000_0003, 32'hDEAD_BEEF, 2'b01);

        // DM_READY asserted while idle must not disturb anything.
        DM_READY = 1'b1; DM_READDATA = 32'h1111_1111;
        tick(); tick();
        DM_READY = 1'b0; DM_READDATA = 32'h0;

        access(1, 0, 3'b010, 32'h0000_0104, 32'h0,        32'h0,         0, 1, 0, 32'h104, 4'b0,    32'h0,         32'hDEAD_BEEF, 2'b11);
        access(1, 0, 3'b000, 32'h0000_0001, 32'h0,        32'h0000_7F00, 0, 0, 0, 32'h000, 4'b0,    32'h0,         32'h0000_007F, 2'b11);

        // Reset in the second WAIT cycle of a load.
        l = '{rd: 1'b1, wr: 1'b0, addr: 32'h100, be: 4'b0, wd: 32'h0, chk_lanes: 1'b0};
        launch_q.push_back(l);
        MEM_READ = 1'b1; FUNCT3 = 3'b010; ADDRESS = 32'h0000_0100;
        tick();
        tick();
        mon_en = 1'b0;
        RESET = 1'b1; MEM_READ = 1'b0;
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        chk("post_rst_dm_read", 32'(DM_READ), 32'd0);
        chk("post_rst_busy", 32'(BUSY), 32'd0);
        chk("post_rst_load_data", LOAD_DATA, 32'h0);
        chk("post_rst_fault_code", 32'(FAULT_CODE), 32'd0);
        mon_en = 1'b1;
        tick();

        access(1, 1, 3'b010, 32'h0000_0200, 32'h55AA_1234, 32'h0,        1, 0, 1, 32'h200, 4'b1111, 32'h55AA_1234, 32'h0,         2'b00);

        repeat (3) tick();
        chk("launch_q_empty", 32'(launch_q.size()), 32'd0);
        chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
